spi_tx_avalon_feeder: RTL and testbench

SPI-slave transmitter: the outbound counterpart of the SPI byte receiver. Software pushes bytes through an Avalon-MM slave port into a small FIFO; the block shifts them out MSB-first on `io_DO` while the SPI master clocks `io_CLK` with `io_CS` asserted (low). It sits beside the receiver on the same SPI pins and Avalon bus and shares their sampling conventions (SPI mode 0).

---
 rtl/spi_tx_pkg.sv | 21 ++
 rtl/spi_tx_fifo.sv | 48 ++++
 rtl/spi_tx_avalon_feeder.sv | 126 ++++++++++++
 tb/tb_spi_tx_avalon_feeder.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/spi_tx_pkg.sv
// spi_tx_pkg: register map, status bit positions and FSM states shared by the SPI transmit feeder.
package spi_tx_pkg;
    localparam logic SPI_TX_REG_DATA = 1'b0;
    localparam logic SPI_TX_REG_CTRL = 1'b1;
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL = 1;
    localparam int STAT_UNF = 2;
    localparam int STAT_OVF = 3;
    localparam int CTRL_CLR_BIT = 8;
    localparam logic [7:0] SPI_TX_IDLE_BYTE = 8'hFF;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT} state_t;
    function automatic logic [31:0] status_word(logic [7:0] count, logic ovf, logic unf, logic full, logic empty);
        logic [3:0] flags;
        flags = '0;
        flags[STAT_OVF] = ovf;
        flags[STAT_UNF] = unf;
        flags[STAT_FULL] = full;
        flags[STAT_EMPTY] = empty;
        return {16'b0, count, 4'b0, flags};
    endfunction
endpackage

// File: rtl/spi_tx_fifo.sv
// spi_tx_fifo: DEPTH x 8 synchronous FIFO with show-ahead head; push into a full FIFO is
// accepted only when a pop frees a slot in the same cycle.
module spi_tx_fifo
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [7:0] count
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [7:0] cnt_q, cnt_d;
    logic do_push, do_pop;
    assign full = cnt_q == 8'(DEPTH);
    assign empty = cnt_q == 8'd0;
    assign count = cnt_q;
    assign dout = mem_q[rd_q];
    always_comb begin
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_d = do_push ? wr_q + AW'(1) : wr_q;
        rd_d = do_pop ? rd_q + AW'(1) : rd_q;
        cnt_d = cnt_q + 8'(do_push) - 8'(do_pop);
    end
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_q <= '0;
            rd_q <= '0;
            cnt_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: rtl/spi_tx_avalon_feeder.sv
// spi_tx_avalon_feeder: Avalon-fed FIFO shifted out MSB-first as an SPI mode-0 slave.
// Define SPI_TX_BYTECOUNT_EN to build the bytes_sent counter (ctrl read bits 15:0).
module spi_tx_avalon_feeder
    import spi_tx_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter logic [7:0] IDLE_BYTE = SPI_TX_IDLE_BYTE
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_Avalon_address,
    input  logic        io_Avalon_write,
    input  logic [31:0] io_Avalon_writedata,
    input  logic        io_Avalon_read,
    output logic [31:0] io_Avalon_readdata,
    input  logic        io_CS,
    input  logic        io_CLK,
    output logic        io_DO,
    output logic        io_DO_oe
);
    state_t state_q, state_d;
    logic [2:0] cs_sync_q, cs_sync_d, sck_sync_q, sck_sync_d, bitcnt_q, bitcnt_d;
    logic [7:0] shifter_q, shifter_d, idle_q, idle_d;
    logic [31:0] readdata_q, readdata_d;
    logic do_q, do_d, oe_q, oe_d, ovf_q, ovf_d, unf_q, unf_d;
    logic cs_fall, cs_rise, sck_rise, sck_fall, wr_data, wr_ctrl, clr, pop, unf_set;
    logic fifo_full, fifo_empty;
    logic [7:0] fifo_dout, fifo_count;
    logic [15:0] sent_val;
    logic unused_wdata;
    assign unused_wdata = ^io_Avalon_writedata[31:9];
    spi_tx_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(wr_data),
        .pop(pop),
        .din(io_Avalon_writedata[7:0]),
        .dout(fifo_dout),
        .full(fifo_full),
        .empty(fifo_empty),
        .count(fifo_count)
    );
    always_comb begin
        cs_sync_d = {cs_sync_q[1:0], io_CS};
        sck_sync_d = {sck_sync_q[1:0], io_CLK};
        cs_fall = !cs_sync_q[1] && cs_sync_q[2];
        cs_rise = cs_sync_q[1] && !cs_sync_q[2];
        sck_rise = sck_sync_q[1] && !sck_sync_q[2];
        sck_fall = !sck_sync_q[1] && sck_sync_q[2];
        state_d = state_q;
        bitcnt_d = bitcnt_q;
        shifter_d = shifter_q;
        pop = 1'b0;
        unf_set = 1'b0;
        if (cs_rise) begin
            state_d = ST_IDLE;
            bitcnt_d = '0;
            shifter_d = 8'hFF;
        end else if (state_q == ST_IDLE) begin
            state_d = cs_fall ? ST_LOAD : ST_IDLE;
        end else if (state_q == ST_LOAD) begin
            pop = !fifo_empty;
            unf_set = fifo_empty;
            shifter_d = fifo_empty ? idle_q : fifo_dout;
            bitcnt_d = '0;
            state_d = ST_SHIFT;
        end else begin
            bitcnt_d = sck_rise ? bitcnt_q + 3'd1 : bitcnt_q;
            // counter back at 0 on a fall means all 8 bits have been sampled
            if (sck_fall && bitcnt_q != 3'd0) shifter_d = {shifter_q[6:0], 1'b1};
            if (sck_fall && bitcnt_q == 3'd0) state_d = ST_LOAD;
        end
        wr_data = io_Avalon_write && io_Avalon_address == SPI_TX_REG_DATA;
        wr_ctrl = io_Avalon_write && io_Avalon_address == SPI_TX_REG_CTRL;
        clr = wr_ctrl && io_Avalon_writedata[CTRL_CLR_BIT];
        idle_d = wr_ctrl ? io_Avalon_writedata[7:0] : idle_q;
        ovf_d = (ovf_q && !clr) || (wr_data && fifo_full && !pop);
        unf_d = (unf_q && !clr) || unf_set;
        oe_d = !cs_sync_q[1];
        do_d = oe_d ? shifter_d[7] : 1'b1;
        readdata_d = !io_Avalon_read ? readdata_q :
                     io_Avalon_address == SPI_TX_REG_CTRL ? {8'b0, idle_q, sent_val} :
                     status_word(fifo_count, ovf_q, unf_q, fifo_full, fifo_empty);
    end
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cs_sync_q <= 3'b111;
            sck_sync_q <= 3'b000;
            bitcnt_q <= '0;
            shifter_q <= 8'hFF;
            idle_q <= IDLE_BYTE;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
            oe_q <= 1'b0;
            do_q <= 1'b1;
            readdata_q <= '0;
        end else begin
            state_q <= state_d;
            cs_sync_q <= cs_sync_d;
            sck_sync_q <= sck_sync_d;
            bitcnt_q <= bitcnt_d;
            shifter_q <= shifter_d;
            idle_q <= idle_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
            oe_q <= oe_d;
            do_q <= do_d;
            readdata_q <= readdata_d;
        end
    end
`ifdef SPI_TX_BYTECOUNT_EN
    logic [15:0] sent_q, sent_d;
    always_comb sent_d = sent_q + 16'(state_q == ST_SHIFT && !cs_rise && sck_fall && bitcnt_q == 3'd0);
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) sent_q <= '0;
        else sent_q <= sent_d;
    end
    assign sent_val = sent_q;
`else
    assign sent_val = '0;
`endif
    assign io_DO = do_q;
    assign io_DO_oe = oe_q;
    assign io_Avalon_readdata = readdata_q;
endmodule

// File: tb/tb_spi_tx_avalon_feeder.sv
// tb_spi_tx_avalon_feeder: directed bench acting as Avalon host and SPI mode-0 master.
// Honors SPI_TX_BYTECOUNT_EN the same way as the design.
module tb_spi_tx_avalon_feeder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic addr = 1'b0, write = 1'b0, read = 1'b0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic cs = 1'b1, sclk = 1'b0;
    logic do_o, oe_o;
    int n_checks = 0, n_pass = 0;
    logic [15:0] exp_sent = '0;
    logic [31:0] r;
    logic [7:0] b;

    spi_tx_avalon_feeder #(.DEPTH(8), .IDLE_BYTE(8'hFF)) dut (
        .clock(clock),
        .reset(reset),
        .io_Avalon_address(addr),
        .io_Avalon_write(write),
        .io_Avalon_writedata(wdata),
        .io_Avalon_read(read),
        .io_Avalon_readdata(rdata),
        .io_CS(cs),
        .io_CLK(sclk),
        .io_DO(do_o),
        .io_DO_oe(oe_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, act, exp);
    endtask

    function automatic logic [15:0] sent_exp();
`ifdef SPI_TX_BYTECOUNT_EN
        return exp_sent;
`else
        return 16'h0;
`endif
    endfunction

    task automatic av_write(input logic a, input logic [31:0] d);
        @(negedge clock);
        addr = a;
        wdata = d;
        write = 1'b1;
        @(negedge clock);
        write = 1'b0;
    endtask

    task automatic av_read(input logic a, output logic [31:0] d);
        @(negedge clock);
        addr = a;
        read = 1'b1;
        @(negedge clock);
        read = 1'b0;
        d = rdata;
    endtask

    task automatic cs_set(input logic v);
        @(negedge clock);
        cs = v;
        repeat (6) @(negedge clock);
    endtask

    // master samples io_DO as it raises SCK; each phase lasts 5 clocks
    task automatic spi_bits(input int n, output logic [7:0] d);
        d = '0;
        for (int i = 0; i < n; i++) begin
            d = {d[6:0], do_o};
            sclk = 1'b1;
            repeat (5) @(negedge clock);
            sclk = 1'b0;
            repeat (5) @(negedge clock);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check("rst_readdata", rdata, 32'h0);
        check("rst_do", {31'b0, do_o}, 32'h1);
        check("rst_oe", {31'b0, oe_o}, 32'h0);
        reset = 1'b1;
        av_read(1'b0, r);
        check("rst_status", r, 32'h0000_0001);
        av_read(1'b1, r);
        check("rst_ctrl", r, 32'h00FF_0000);

        av_write(1'b0, 32'h7A);
        av_write(1'b0, 32'h80);
        av_read(1'b0, r);
        check("two_pushed", r, 32'h0000_0200);
        cs_set(1'b0);
        check("oe_on", {31'b0, oe_o}, 32'h1);
        spi_bits(8, b);
        check("byte_7a", {24'b0, b}, 32'h7A);
        spi_bits(8, b);
        check("byte_80", {24'b0, b}, 32'h80);
        exp_sent += 16'd2;
        cs_set(1'b1);
        check("oe_off", {31'b0, oe_o}, 32'h0);
        check("do_forced", {31'b0, do_o}, 32'h1);
        av_read(1'b0, r);
        check("drained_unf", r, 32'h0000_0005);
        av_read(1'b1, r);
        check("ctrl_sent2", r, {8'h00, 8'hFF, sent_exp()});
        av_write(1'b1, 32'h1FF);
        av_read(1'b0, r);
        check("clr_flags", r, 32'h0000_0001);

        cs_set(1'b0);
        spi_bits(8, b);
        check("underrun_ff", {24'b0, b}, 32'hFF);
        exp_sent += 16'd1;
        cs_set(1'b1);
        av_read(1'b0, r);
        check("unf_set", r, 32'h0000_0005);
        av_write(1'b1, 32'h100);
        av_read(1'b0, r);
        check("unf_clear", r, 32'h0000_0001);
        av_read(1'b1, r);
        check("ctrl_idle00", r, {8'h00, 8'h00, sent_exp()});

        av_write(1'b1, 32'h10C);
        cs_set(1'b0);
        spi_bits(8, b);
        check("idle_0c", {24'b0, b}, 32'h0C);
        exp_sent += 16'd1;
        cs_set(1'b1);
        av_read(1'b1, r);
        check("ctrl_idle0c", r, {8'h00, 8'h0C, sent_exp()});
        av_write(1'b1, 32'h10C);

        for (int k = 1; k <= 9; k++) av_write(1'b0, 32'(k));
        av_read(1'b0, r);
        check("ovf_full", r, 32'h0000_080A);
        cs_set(1'b0);
        for (int k = 1; k <= 8; k++) begin
            spi_bits(8, b);
            check($sformatf("fifo_byte%0d", k), {24'b0, b}, 32'(k));
        end
        spi_bits(8, b);
        check("ninth_dropped", {24'b0, b}, 32'h0C);
        exp_sent += 16'd9;
        cs_set(1'b1);
        av_read(1'b0, r);
        check("ovf_unf", r, 32'h0000_000D);
        av_write(1'b1, 32'h1FF);
        av_read(1'b0, r);
        check("clr_all", r, 32'h0000_0001);

        av_write(1'b0, 32'h40);
        av_write(1'b0, 32'h0C);
        cs_set(1'b0);
        spi_bits(3, b);
        cs_set(1'b1);
        cs_set(1'b0);
        spi_bits(8, b);
        check("after_abort", {24'b0, b}, 32'h0C);
        exp_sent += 16'd1;
        cs_set(1'b1);
        av_read(1'b0, r);
        check("abort_status", r, 32'h0000_0005);
        av_read(1'b1, r);
        check("abort_sent", r, {8'h00, 8'hFF, sent_exp()});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
